// File: rtl/disp_colr_adapt.sv
// -----------------------------------------------------------------------------
// disp_colr_adapt
//
// Purpose:
//   Pixel-clock colour-depth adapter between the display controller and the
//   TMDS/DVI generator. Converts BPC_IN-bit RGB to BPC_OUT-bit RGB:
//     - expansion (BPC_OUT >= BPC_IN): cyclic MSB-first bit replication
//     - reduction (BPC_OUT <  BPC_IN): truncate, round, spatial 4x4 Bayer
//       dither or spatio-temporal Bayer dither, selected by MODE
//   Colour is forced to 0 whenever the delayed data enable is low. Syncs and
//   data enable are delayed, never modified, so they stay aligned with colour.
//
// Flow control:
//   There is no valid/ready handshake. in_de qualifies the input pixel in the
//   same cycle, out_de qualifies the output pixel; one pixel is accepted and
//   one produced on every clk_pix cycle with a fixed latency of 2 cycles.
//
// Parameters:
//   BPC_IN   input bits per colour channel (1-12)
//   BPC_OUT  output bits per colour channel (1-12)
//   MODE     reduction mode: 0 truncate, 1 round, 2 spatial dither,
//            3 temporal dither (ignored when BPC_OUT >= BPC_IN)
//
// Ports:
//   clk_pix             pixel clock
//   rst_pix_n           asynchronous active-low reset
//   in_frame            start-of-frame pulse (one cycle)
//   in_de/hsync/vsync   input data enable and syncs
//   in_r/g/b            input colour, BPC_IN bits each
//   out_de/hsync/vsync  inputs delayed by 2 cycles
//   out_r/g/b           converted colour, BPC_OUT bits each
// -----------------------------------------------------------------------------
module disp_colr_adapt #(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter int MODE    = 2
) (
  input  logic               clk_pix,
  input  logic               rst_pix_n,
  input  logic               in_frame,
  input  logic               in_de,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic [BPC_IN-1:0]  in_r,
  input  logic [BPC_IN-1:0]  in_g,
  input  logic [BPC_IN-1:0]  in_b,
  output logic               out_de,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic [BPC_OUT-1:0] out_r,
  output logic [BPC_OUT-1:0] out_g,
  output logic [BPC_OUT-1:0] out_b
);

  // Number of bits dropped per channel; <= 0 means expansion.
  localparam int D = BPC_IN - BPC_OUT;

  // Bayer entries are 4 bits; they are rescaled to D bits by one shift,
  // right for D <= 4 and left for D > 4. Only one of the two is non-zero.
  localparam int SH_R   = (D > 0 && D <= 4) ? 4 - D : 0;
  localparam int SH_L   = (D > 4) ? D - 4 : 0;
  localparam int RND_SH = (D > 0) ? D - 1 : 0;

  // ---------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------
  logic [15:0] xc_q;
  logic [15:0] yc_q;
  logic [1:0]  fc_q;
  logic        de_prev_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      xc_q      <= '0;
      yc_q      <= '0;
      fc_q      <= '0;
      de_prev_q <= 1'b0;
    end else begin
      de_prev_q <= in_de;
      xc_q      <= in_de ? xc_q + 16'd1 : '0;
      // A frame start overrides a coincident end-of-line increment.
      if (in_frame) begin
        yc_q <= '0;
        fc_q <= fc_q + 2'd1;
      end else if (de_prev_q && !in_de) begin
        yc_q <= yc_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Threshold / rounding constant for the pixel sampled this cycle
  // ---------------------------------------------------------------------------
  logic [1:0]  bx;
  logic [1:0]  by;
  logic [3:0]  bayer;
  logic [31:0] add_w;

  always_comb begin
    bx = xc_q[1:0];
    by = yc_q[1:0];
    if (MODE == 3) begin
      // Shifting the matrix diagonally each frame spreads the pattern in time.
      bx = xc_q[1:0] + fc_q;
      by = yc_q[1:0] + fc_q;
    end

    bayer = 4'd0;
    case ({by, bx})
      4'h0: bayer = 4'd0;
      4'h1: bayer = 4'd8;
      4'h2: bayer = 4'd2;
      4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;
      4'h5: bayer = 4'd4;
      4'h6: bayer = 4'd14;
      4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;
      4'h9: bayer = 4'd11;
      4'hA: bayer = 4'd1;
      4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;
      4'hD: bayer = 4'd7;
      4'hE: bayer = 4'd13;
      4'hF: bayer = 4'd5;
      default: bayer = 4'd0;
    endcase

    add_w = '0;
    if (D > 0) begin
      if (MODE == 1) begin
        add_w = 32'd1 << RND_SH;
      end else if (MODE >= 2) begin
        add_w = ({28'd0, bayer} >> SH_R) << SH_L;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: register syncs, colour and the per-pixel add constant
  // ---------------------------------------------------------------------------
  logic                   s1_de;
  logic                   s1_hs;
  logic                   s1_vs;
  logic [2:0][BPC_IN-1:0] s1_c;
  logic [BPC_IN:0]        s1_add;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      s1_de  <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_c   <= '0;
      s1_add <= '0;
    end else begin
      s1_de  <= in_de;
      s1_hs  <= in_hsync;
      s1_vs  <= in_vsync;
      s1_c   <= {in_b, in_g, in_r};
      s1_add <= add_w[BPC_IN:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion (combinational, between stage 1 and stage 2)
  // ---------------------------------------------------------------------------
  logic [2:0][BPC_OUT-1:0] nxt_c;

  if (D > 0) begin : g_reduce
    localparam logic [BPC_IN:0] MAXV = (BPC_IN + 1)'((1 << BPC_OUT) - 1);

    for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [BPC_IN:0]    sum;
      logic [BPC_IN:0]    shr;
      logic [BPC_OUT-1:0] res;

      // One extra bit keeps in + threshold from wrapping before saturation.
      always_comb begin
        sum = {1'b0, s1_c[c]} + s1_add;
        shr = sum >> D;
        res = (shr > MAXV) ? MAXV[BPC_OUT-1:0] : shr[BPC_OUT-1:0];
      end

      assign nxt_c[c] = s1_de ? res : '0;
    end
  end else begin : g_expand
    for (genvar c = 0; c < 3; c++) begin : g_ch
      logic [BPC_OUT-1:0] rep;

      // Output bit i counted from the MSB takes input bit (i mod BPC_IN)
      // counted from the MSB, so the input pattern repeats as often as needed.
      for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
        assign rep[BPC_OUT-1-i] = s1_c[c][BPC_IN-1-(i % BPC_IN)];
      end

      assign nxt_c[c] = s1_de ? rep : '0;
    end

    logic unused_add;
    assign unused_add = ^s1_add;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output registers
  // ---------------------------------------------------------------------------
  logic [2:0][BPC_OUT-1:0] out_c;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_c     <= '0;
    end else begin
      out_de    <= s1_de;
      out_hsync <= s1_hs;
      out_vsync <= s1_vs;
      out_c     <= nxt_c;
    end
  end

  assign out_r = out_c[0];
  assign out_g = out_c[1];
  assign out_b = out_c[2];

  // Only the low two counter bits index the 4x4 matrix.
  logic unused_bits;
  assign unused_bits = ^{xc_q[15:2], yc_q[15:2], add_w[31:BPC_IN+1]};

endmodule

// File: tb/tb_disp_colr_adapt.sv
`timescale 1ns/1ps
module tb_disp_colr_adapt;

  // ---------------------------------------------------------------------------
  // Clock / reset / shared stimulus
  // ---------------------------------------------------------------------------
  logic clk_pix   = 1'b0;
  logic rst_pix_n = 1'b0;
  logic in_frame  = 1'b0;
  logic in_de     = 1'b0;
  logic in_hsync  = 1'b0;
  logic in_vsync  = 1'b0;
  logic [4:0] i5_r = '0, i5_g = '0, i5_b = '0;
  logic [7:0] i8_r = '0, i8_g = '0, i8_b = '0;

  always #5 clk_pix = ~clk_pix;

  // {de, hsync, vsync} per instance
  logic [2:0]  sy_e8, sy_e12, sy_m0, sy_m1, sy_m2, sy_m3;
  logic [7:0]  e8_r, e8_g, e8_b;
  logic [11:0] e12_r, e12_g, e12_b;
  logic [4:0]  m0_r, m0_g, m0_b;
  logic [4:0]  m1_r, m1_g, m1_b;
  logic [4:0]  m2_r, m2_g, m2_b;
  logic [4:0]  m3_r, m3_g, m3_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] cap2 [8];
  logic [4:0] cap3 [8];
  logic [7:0] cap_e8 [8];
  logic       cap_pre;

  // ---------------------------------------------------------------------------
  // DUT instances: two expansions, four reduction modes
  // ---------------------------------------------------------------------------
  disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .MODE(2)) u_e8 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i5_r), .in_g(i5_g), .in_b(i5_b),
    .out_de(sy_e8[2]), .out_hsync(sy_e8[1]), .out_vsync(sy_e8[0]),
    .out_r(e8_r), .out_g(e8_g), .out_b(e8_b));

  disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(12), .MODE(0)) u_e12 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i5_r), .in_g(i5_g), .in_b(i5_b),
    .out_de(sy_e12[2]), .out_hsync(sy_e12[1]), .out_vsync(sy_e12[0]),
    .out_r(e12_r), .out_g(e12_g), .out_b(e12_b));

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(0)) u_m0 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i8_r), .in_g(i8_g), .in_b(i8_b),
    .out_de(sy_m0[2]), .out_hsync(sy_m0[1]), .out_vsync(sy_m0[0]),
    .out_r(m0_r), .out_g(m0_g), .out_b(m0_b));

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(1)) u_m1 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i8_r), .in_g(i8_g), .in_b(i8_b),
    .out_de(sy_m1[2]), .out_hsync(sy_m1[1]), .out_vsync(sy_m1[0]),
    .out_r(m1_r), .out_g(m1_g), .out_b(m1_b));

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(2)) u_m2 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i8_r), .in_g(i8_g), .in_b(i8_b),
    .out_de(sy_m2[2]), .out_hsync(sy_m2[1]), .out_vsync(sy_m2[0]),
    .out_r(m2_r), .out_g(m2_g), .out_b(m2_b));

  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(3)) u_m3 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .in_frame(in_frame), .in_de(in_de),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_r(i8_r), .in_g(i8_g), .in_b(i8_b),
    .out_de(sy_m3[2]), .out_hsync(sy_m3[1]), .out_vsync(sy_m3[0]),
    .out_r(m3_r), .out_g(m3_g), .out_b(m3_b));

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic frame_pulse();
    in_de    = 1'b0;
    in_frame = 1'b1;
    tick();
    in_frame = 1'b0;
    tick();
  endtask

  // Drives n active pixels of green value v, then one blank cycle (optionally
  // carrying in_frame). Output of pixel k is captured after tick k+1.
  task automatic run_line(input int n, input logic [7:0] v, input logic frame_end);
    for (int j = 0; j <= n; j++) begin
      in_de    = (j < n);
      i8_g     = v;
      in_frame = (j == n) ? frame_end : 1'b0;
      tick();
      if (j == 0) cap_pre = sy_e8[2];
      if (j >= 1) begin
        cap2[j-1]   = m2_g;
        cap3[j-1]   = m3_g;
        cap_e8[j-1] = e8_r;
      end
    end
    in_frame = 1'b0;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({sy_e8, sy_e12, sy_m0, sy_m1, sy_m2, sy_m3} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_sync got %h want 0", {sy_e8, sy_e12, sy_m0, sy_m1, sy_m2, sy_m3});
    end
    n_cmp++;
    if ({e8_r, e8_g, e8_b, e12_r, e12_g, e12_b} !== 60'd0) begin
      n_err++;
      $display("FAIL reset_expand got %h want 0", {e8_r, e8_g, e8_b, e12_r, e12_g, e12_b});
    end
    n_cmp++;
    if ({m0_r, m0_g, m0_b, m1_r, m1_g, m1_b, m2_r, m2_g, m2_b, m3_r, m3_g, m3_b} !== 60'd0) begin
      n_err++;
      $display("FAIL reset_reduce got %h want 0",
               {m0_r, m0_g, m0_b, m1_r, m1_g, m1_b, m2_r, m2_g, m2_b, m3_r, m3_g, m3_b});
    end
    tick();
    tick();
    rst_pix_n = 1'b1;
    tick();
    n_cmp++;
    if ({sy_m1, m1_r, e8_r} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_release got %h want 0", {sy_m1, m1_r, e8_r});
    end
  endtask

  task automatic test_expand();
    in_de = 1'b1; in_hsync = 1'b1; in_vsync = 1'b0;
    i5_r = 5'b10101; i5_g = 5'h1F; i5_b = 5'h00;
    tick();
    in_hsync = 1'b0; in_vsync = 1'b1;
    i5_r = 5'b00110; i5_g = 5'h00; i5_b = 5'b10000;
    tick();
    n_cmp++;
    if ({e8_r, e8_g, e8_b} !== 24'hADFF00) begin
      n_err++;
      $display("FAIL expand8_v1 got %h want %h", {e8_r, e8_g, e8_b}, 24'hADFF00);
    end
    n_cmp++;
    if ({e12_r, e12_g, e12_b} !== 36'hAD6FFF000) begin
      n_err++;
      $display("FAIL expand12_v1 got %h want %h", {e12_r, e12_g, e12_b}, 36'hAD6FFF000);
    end
    n_cmp++;
    if (sy_e8 !== 3'b110) begin
      n_err++;
      $display("FAIL expand_sync_v1 got %b want 110", sy_e8);
    end
    in_de = 1'b0; in_vsync = 1'b0;
    tick();
    n_cmp++;
    if ({e8_r, e8_g, e8_b} !== 24'h310084) begin
      n_err++;
      $display("FAIL expand8_v2 got %h want %h", {e8_r, e8_g, e8_b}, 24'h310084);
    end
    n_cmp++;
    if ({e12_r, e12_g, e12_b} !== 36'h318000842) begin
      n_err++;
      $display("FAIL expand12_v2 got %h want %h", {e12_r, e12_g, e12_b}, 36'h318000842);
    end
    n_cmp++;
    if (sy_e12 !== 3'b101) begin
      n_err++;
      $display("FAIL expand_sync_v2 got %b want 101", sy_e12);
    end
    tick();
    tick();
  endtask

  task automatic test_reduce();
    in_de = 1'b1;
    i8_r = 8'hFF; i8_g = 8'h04; i8_b = 8'hFC;
    tick();
    i8_r = 8'h0B; i8_g = 8'h0C; i8_b = 8'h80;
    tick();
    n_cmp++;
    if ({m0_r, m0_g, m0_b} !== {5'h1F, 5'h00, 5'h1F}) begin
      n_err++;
      $display("FAIL trunc_v1 got %h want %h", {m0_r, m0_g, m0_b}, {5'h1F, 5'h00, 5'h1F});
    end
    n_cmp++;
    if ({m1_r, m1_g, m1_b} !== {5'h1F, 5'h01, 5'h1F}) begin
      n_err++;
      $display("FAIL round_v1 got %h want %h", {m1_r, m1_g, m1_b}, {5'h1F, 5'h01, 5'h1F});
    end
    in_de = 1'b0;
    tick();
    n_cmp++;
    if ({m0_r, m0_g, m0_b} !== {5'h01, 5'h01, 5'h10}) begin
      n_err++;
      $display("FAIL trunc_v2 got %h want %h", {m0_r, m0_g, m0_b}, {5'h01, 5'h01, 5'h10});
    end
    n_cmp++;
    if ({m1_r, m1_g, m1_b} !== {5'h01, 5'h02, 5'h10}) begin
      n_err++;
      $display("FAIL round_v2 got %h want %h", {m1_r, m1_g, m1_b}, {5'h01, 5'h02, 5'h10});
    end
    i8_r = '0; i8_b = '0;
    tick();
    tick();
  endtask

  task automatic test_spatial();
    int pat0 [4];
    int pat1 [4];
    pat0 = '{0, 1, 0, 1};
    pat1 = '{1, 0, 1, 0};
    frame_pulse();
    run_line(8, 8'h04, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap2[i] !== 5'(pat0[i % 4])) begin
        n_err++;
        $display("FAIL spatial_y0_x%0d got %0d want %0d", i, cap2[i], pat0[i % 4]);
      end
    end
    // fc is 1 after the single frame pulse since reset.
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap3[i] !== 5'(pat0[i])) begin
        n_err++;
        $display("FAIL temporal_fc1_x%0d got %0d want %0d", i, cap3[i], pat0[i]);
      end
    end
    run_line(8, 8'h04, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap2[i] !== 5'(pat1[i % 4])) begin
        n_err++;
        $display("FAIL spatial_y1_x%0d got %0d want %0d", i, cap2[i], pat1[i % 4]);
      end
    end
  endtask

  task automatic test_temporal();
    int exp3 [4][4];
    int exp2 [4];
    // Frames 1..4 after reset see fc = 1, 2, 3, 0; input 8'h06.
    exp3 = '{'{1, 1, 1, 1}, '{0, 1, 0, 1}, '{1, 1, 1, 1}, '{0, 1, 0, 1}};
    exp2 = '{0, 1, 0, 1};
    in_de = 1'b0;
    rst_pix_n = 1'b0;
    tick();
    rst_pix_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_pulse();
      run_line(4, 8'h06, 1'b0);
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (cap3[i] !== 5'(exp3[k][i])) begin
          n_err++;
          $display("FAIL temporal_f%0d_x%0d got %0d want %0d", k + 1, i, cap3[i], exp3[k][i]);
        end
      end
      n_cmp++;
      if (cap2[0] !== 5'(exp2[0]) || cap2[1] !== 5'(exp2[1])) begin
        n_err++;
        $display("FAIL spatial_static_f%0d got %0d,%0d want 0,1", k + 1, cap2[0], cap2[1]);
      end
    end
  endtask

  task automatic test_frame_edge();
    // Current yc is 1; end this line with in_frame on the falling-edge cycle.
    run_line(4, 8'h04, 1'b1);
    n_cmp++;
    if ({cap2[0], cap2[1], cap2[2], cap2[3]} !== {5'd1, 5'd0, 5'd1, 5'd0}) begin
      n_err++;
      $display("FAIL frame_edge_pre got %h want %h",
               {cap2[0], cap2[1], cap2[2], cap2[3]}, {5'd1, 5'd0, 5'd1, 5'd0});
    end
    run_line(4, 8'h04, 1'b0);
    n_cmp++;
    if ({cap2[0], cap2[1], cap2[2], cap2[3]} !== {5'd0, 5'd1, 5'd0, 5'd1}) begin
      n_err++;
      $display("FAIL frame_edge_yc0 got %h want %h",
               {cap2[0], cap2[1], cap2[2], cap2[3]}, {5'd0, 5'd1, 5'd0, 5'd1});
    end
  endtask

  task automatic test_blanking();
    logic [3:0] hs_pat;
    logic [3:0] vs_pat;
    hs_pat = 4'b1011;
    vs_pat = 4'b0110;
    in_de = 1'b0;
    i5_r = 5'h1F; i5_g = 5'h1F; i5_b = 5'h1F;
    i8_r = 8'hFF; i8_g = 8'hFF; i8_b = 8'hFF;
    for (int j = 0; j <= 4; j++) begin
      in_hsync = (j < 4) ? hs_pat[j] : 1'b0;
      in_vsync = (j < 4) ? vs_pat[j] : 1'b0;
      tick();
      if (j >= 1) begin
        n_cmp++;
        if (sy_e8 !== {1'b0, hs_pat[j-1], vs_pat[j-1]} || sy_m3 !== sy_e8) begin
          n_err++;
          $display("FAIL blank_sync_%0d got %b/%b want %b", j - 1, sy_e8, sy_m3,
                   {1'b0, hs_pat[j-1], vs_pat[j-1]});
        end
        n_cmp++;
        if ({e8_r, e8_g, e8_b, e12_r, m1_r, m1_g, m1_b, m2_r, m3_g} !== 61'd0) begin
          n_err++;
          $display("FAIL blank_colour_%0d got %h want 0", j - 1,
                   {e8_r, e8_g, e8_b, e12_r, m1_r, m1_g, m1_b, m2_r, m3_g});
        end
      end
    end
    tick();
  endtask

  task automatic test_async_reset();
    in_de = 1'b1;
    i8_r = 8'hFF;
    i5_r = 5'h1F;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({sy_m0[2], m0_r, e8_r} !== {1'b1, 5'h1F, 8'hFF}) begin
      n_err++;
      $display("FAIL pre_reset got %h want %h", {sy_m0[2], m0_r, e8_r}, {1'b1, 5'h1F, 8'hFF});
    end
    #2;
    rst_pix_n = 1'b0;
    #1;
    n_cmp++;
    if ({sy_e8, sy_m1, e8_r, e8_g, e8_b, m1_r, m1_g, m1_b} !== 45'd0) begin
      n_err++;
      $display("FAIL async_reset got %h want 0", {sy_e8, sy_m1, e8_r, e8_g, e8_b, m1_r, m1_g, m1_b});
    end
    in_de = 1'b0;
    tick();
    rst_pix_n = 1'b1;
    i5_r = 5'b10101;
    run_line(4, 8'h04, 1'b0);
    n_cmp++;
    if (cap_pre !== 1'b0) begin
      n_err++;
      $display("FAIL realign_early got %b want 0", cap_pre);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_e8[i] !== 8'hAD) begin
        n_err++;
        $display("FAIL realign_px%0d got %h want ad", i, cap_e8[i]);
      end
    end
    n_cmp++;
    if ({cap2[0], cap2[1], cap2[2], cap2[3]} !== {5'd0, 5'd1, 5'd0, 5'd1}) begin
      n_err++;
      $display("FAIL post_reset_y0 got %h want %h",
               {cap2[0], cap2[1], cap2[2], cap2[3]}, {5'd0, 5'd1, 5'd0, 5'd1});
    end
    run_line(4, 8'h04, 1'b0);
    n_cmp++;
    if ({cap2[0], cap2[1], cap2[2], cap2[3]} !== {5'd1, 5'd0, 5'd1, 5'd0}) begin
      n_err++;
      $display("FAIL post_reset_y1 got %h want %h",
               {cap2[0], cap2[1], cap2[2], cap2[3]}, {5'd1, 5'd0, 5'd1, 5'd0});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_expand();
    test_reduce();
    test_spatial();
    test_temporal();
    test_frame_edge();
    test_blanking();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
